// File: rtl/spi_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_controller_if
// Purpose  : SPI master bus bundle: control handshake plus the serial link.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_controller_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_data;
    logic             sck;
    logic             sdo;
    logic             sdi;
    logic             ce;

    modport master (
        input  start, tx_data, sdi,
        output busy, done, rx_data, sck, sdo, ce
    );

    modport slave (
        output start, tx_data, sdi,
        input  busy, done, rx_data, sck, sdo, ce
    );
endinterface
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module   : spi_controller
// Purpose  : SPI master; MSB-first shift out on sdo with simultaneous sdi capture.
// Revision : 1.0 - initial release
// ============================================================================
module spi_controller #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    spi_controller_if.master  bus
);
    localparam int c_PW = $clog2(CLK_DIV);
    localparam int c_BW = $clog2(WIDTH);
    localparam logic [c_PW-1:0] c_PHASE_LAST = c_PW'(CLK_DIV - 1);
    localparam logic [c_BW-1:0] c_BIT_FIRST  = c_BW'(WIDTH - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LEAD  = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
    localparam logic [2:0] c_ST_TRAIL = 3'd3;
    localparam logic [2:0] c_ST_GAP   = 3'd4;

    logic [2:0]       r_state,   w_state_nx;
    logic [c_PW-1:0]  r_phase,   w_phase_nx;
    logic [c_BW-1:0]  r_bit,     w_bit_nx;
    logic             r_high,    w_high_nx;
    logic [WIDTH-1:0] r_tx,      w_tx_nx;
    logic [WIDTH-1:0] r_rx_sh,   w_rx_sh_nx;
    logic [WIDTH-1:0] r_rx_data, w_rx_data_nx;
    logic             r_done,    w_done_nx;
    logic             r_sck,     w_sck_nx;
    logic             r_ce,      w_ce_nx;
    logic             r_busy,    w_busy_nx;
    logic             r_sdi_meta, r_sdi_sync;
    logic             w_phase_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sdi_meta <= 1'b0;
            r_sdi_sync <= 1'b0;
        end else begin
            r_sdi_meta <= bus.sdi;
            r_sdi_sync <= r_sdi_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_phase   <= '0;
            r_bit     <= '0;
            r_high    <= 1'b0;
            r_tx      <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_done    <= 1'b0;
            r_sck     <= 1'b0;
            r_ce      <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_phase   <= w_phase_nx;
            r_bit     <= w_bit_nx;
            r_high    <= w_high_nx;
            r_tx      <= w_tx_nx;
            r_rx_sh   <= w_rx_sh_nx;
            r_rx_data <= w_rx_data_nx;
            r_done    <= w_done_nx;
            r_sck     <= w_sck_nx;
            r_ce      <= w_ce_nx;
            r_busy    <= w_busy_nx;
        end
    end

    assign w_phase_end = (r_phase == c_PHASE_LAST);

    always_comb begin
        w_state_nx   = r_state;
        w_phase_nx   = w_phase_end ? '0 : r_phase + 1'b1;
        w_bit_nx     = r_bit;
        w_high_nx    = r_high;
        w_tx_nx      = r_tx;
        w_rx_sh_nx   = r_rx_sh;
        w_rx_data_nx = r_rx_data;
        w_done_nx    = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_phase_nx = '0;
                if (bus.start) begin
                    w_state_nx = c_ST_LEAD;
                    w_tx_nx    = bus.tx_data;
                    w_bit_nx   = c_BIT_FIRST;
                    w_high_nx  = 1'b0;
                    w_rx_sh_nx = '0;
                end
            end
            c_ST_LEAD: begin
                if (w_phase_end) begin
                    w_state_nx = c_ST_SHIFT;
                    w_high_nx  = 1'b1;
                end
            end
            c_ST_SHIFT: begin
                if (w_phase_end) begin
                    if (r_high) begin
                        // Sample at the end of the high phase; sdo moves with the fall,
                        // except after the last bit so the LSB stays on the line.
                        w_rx_sh_nx = {r_rx_sh[WIDTH-2:0], r_sdi_sync};
                        w_high_nx  = 1'b0;
                        if (r_bit != '0) begin
                            w_tx_nx = r_tx << 1;
                        end
                    end else if (r_bit == '0) begin
                        w_state_nx = c_ST_TRAIL;
                    end else begin
                        w_bit_nx  = r_bit - 1'b1;
                        w_high_nx = 1'b1;
                    end
                end
            end
            c_ST_TRAIL: begin
                if (w_phase_end) begin
                    w_state_nx   = c_ST_GAP;
                    w_done_nx    = 1'b1;
                    w_rx_data_nx = r_rx_sh;
                    w_tx_nx      = '0;
                end
            end
            c_ST_GAP: begin
                if (w_phase_end) begin
                    w_state_nx = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nx = c_ST_IDLE;
                w_phase_nx = '0;
            end
        endcase

        // Line outputs are registered from the next state so they change with it.
        w_sck_nx  = (w_state_nx == c_ST_SHIFT) && w_high_nx;
        w_ce_nx   = (w_state_nx == c_ST_LEAD) || (w_state_nx == c_ST_SHIFT) ||
                    (w_state_nx == c_ST_TRAIL);
        w_busy_nx = (w_state_nx != c_ST_IDLE);
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;
    assign bus.sck     = r_sck;
    assign bus.sdo     = r_tx[WIDTH-1];
    assign bus.ce      = r_ce;
endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_controller
// Purpose  : Self-checking bench for spi_controller (WIDTH=8, CLK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_v = 1'b0;
    logic [7:0] tx_v = 8'h00;
    int         sdi_mode = 0;   // 0: loopback from sdo, 1: tied high, 2: tied low
    int         checks = 0;
    int         failures = 0;

    spi_controller_if #(.WIDTH(8)) bus ();

    spi_controller #(.WIDTH(8), .CLK_DIV(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    assign bus.start   = start_v;
    assign bus.tx_data = tx_v;
    assign bus.sdi     = (sdi_mode == 0) ? bus.sdo : (sdi_mode == 1);

    always #5 clk = ~clk;

    // Behavioural peer receiver: shifts on sck rise, latches on ce fall.
    logic [7:0] rcv_sh = 8'h00;
    logic [7:0] rcv_data = 8'h00;
    logic       rcv_valid = 1'b0;
    always @(posedge bus.sck) rcv_sh <= {rcv_sh[6:0], bus.sdo};
    always @(bus.ce) begin
        if (bus.ce) rcv_valid <= 1'b0;
        else begin
            rcv_data  <= rcv_sh;
            rcv_valid <= 1'b1;
        end
    end

    logic       tr_ce   [0:199];
    logic       tr_sck  [0:199];
    logic       tr_busy [0:199];
    logic       tr_done [0:199];
    logic       tr_sdo  [0:199];
    logic [7:0] tr_rx   [0:199];

    typedef struct {
        logic [7:0] tx;
        int         mode;
        logic [7:0] exp_sdo;
        logic [7:0] exp_rx;
        logic       exp_lsb;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample(input int k);
        tr_ce[k]   = bus.ce;
        tr_sck[k]  = bus.sck;
        tr_busy[k] = bus.busy;
        tr_done[k] = bus.done;
        tr_sdo[k]  = bus.sdo;
        tr_rx[k]   = bus.rx_data;
    endtask

    task automatic run(input logic [7:0] w, input int n, input int hold_to,
                       input logic [7:0] w2, input int w2_at, input int pulse_at);
        @(negedge clk);
        sample(0);
        start_v = 1'b1;
        tx_v    = w;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            sample(k);
            start_v = (k < hold_to) || (k == pulse_at);
            if (k == w2_at) tx_v = w2;
        end
        start_v = 1'b0;
    endtask

    // Expected per-cycle level relative to the accept cycle.
    function automatic logic exp_sig(input int kind, input int rel);
        case (kind)
            0:       return (rel >= 1) && (rel <= 72);
            1:       return (rel >= 5) && (rel <= 68) && (((rel - 5) % 8) < 4);
            2:       return (rel >= 1) && (rel <= 76);
            default: return (rel == 73);
        endcase
    endfunction

    function automatic int pattern_errors(input int kind, input int n, input int acc0, input int acc1);
        int   errs = 0;
        logic act, exp;
        for (int k = 1; k <= n; k++) begin
            case (kind)
                0:       act = tr_ce[k];
                1:       act = tr_sck[k];
                2:       act = tr_busy[k];
                default: act = tr_done[k];
            endcase
            exp = exp_sig(kind, k - acc0) || ((acc1 >= 0) && exp_sig(kind, k - acc1));
            if (act !== exp) errs++;
        end
        return errs;
    endfunction

    function automatic int count_rises(input int n);
        int c = 0;
        for (int k = 1; k <= n; k++)
            if (tr_sck[k] && !tr_sck[k-1]) c++;
        return c;
    endfunction

    function automatic int sck_without_ce(input int n);
        int c = 0;
        for (int k = 0; k <= n; k++)
            if (tr_sck[k] && !tr_ce[k]) c++;
        return c;
    endfunction

    function automatic logic [7:0] sdo_at_rises(input int acc);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], tr_sdo[acc + 5 + 8*i]};
        return b;
    endfunction

    initial begin
        int cnt;
        vecs[0] = '{tx: 8'hA5, mode: 0, exp_sdo: 8'hA5, exp_rx: 8'hA5, exp_lsb: 1'b1};
        vecs[1] = '{tx: 8'h3C, mode: 0, exp_sdo: 8'h3C, exp_rx: 8'h3C, exp_lsb: 1'b0};
        vecs[2] = '{tx: 8'h3C, mode: 1, exp_sdo: 8'h3C, exp_rx: 8'hFF, exp_lsb: 1'b0};
        vecs[3] = '{tx: 8'h5A, mode: 2, exp_sdo: 8'h5A, exp_rx: 8'h00, exp_lsb: 1'b0};
        vecs[4] = '{tx: 8'hC3, mode: 0, exp_sdo: 8'hC3, exp_rx: 8'hC3, exp_lsb: 1'b1};

        // Reset for 3 cycles, then idle with start low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ce", bus.ce, 0);
        check("rst_sck", bus.sck, 0);
        check("rst_sdo", bus.sdo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rx", bus.rx_data, 0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.sck || bus.ce || bus.busy || bus.done) cnt++;
        end
        check("idle_activity", cnt, 0);

        // Single transfers from the vector table.
        for (int v = 0; v < 5; v++) begin
            sdi_mode = vecs[v].mode;
            run(vecs[v].tx, 80, 1, 8'h00, -1, -1);
            check("ce_window", pattern_errors(0, 80, 0, -1), 0);
            check("sck_pattern", pattern_errors(1, 80, 0, -1), 0);
            check("busy_window", pattern_errors(2, 80, 0, -1), 0);
            check("done_pulse", pattern_errors(3, 80, 0, -1), 0);
            check("sck_rises", count_rises(80), 8);
            check("sck_no_ce", sck_without_ce(80), 0);
            check("sdo_bits", sdo_at_rises(0), vecs[v].exp_sdo);
            check("sdo_trail_lsb", tr_sdo[70], vecs[v].exp_lsb);
            check("sdo_gap", tr_sdo[74], 0);
            check("rx_at_done", tr_rx[73], vecs[v].exp_rx);
            check("rx_held", tr_rx[80], vecs[v].exp_rx);
            check("rcv_data", rcv_data, vecs[v].tx);
            check("rcv_valid", rcv_valid, 1);
        end

        // Back-to-back with start held: 0x3C then 0xC3.
        sdi_mode = 0;
        run(8'h3C, 155, 80, 8'hC3, 2, -1);
        check("b2b_ce", pattern_errors(0, 155, 0, 77), 0);
        check("b2b_ce_rise2", {tr_ce[77], tr_ce[78]}, 2'b01);
        check("b2b_done", pattern_errors(3, 155, 0, 77), 0);
        check("b2b_busy", pattern_errors(2, 155, 0, 77), 0);
        check("b2b_sdo1", sdo_at_rises(0), 8'h3C);
        check("b2b_sdo2", sdo_at_rises(77), 8'hC3);
        check("b2b_rx2", tr_rx[150], 8'hC3);

        // start during busy and tx_data change after acceptance are ignored.
        run(8'hA5, 160, 1, 8'h00, 10, 20);
        check("ign_ce", pattern_errors(0, 160, 0, -1), 0);
        check("ign_done", pattern_errors(3, 160, 0, -1), 0);
        check("ign_rises", count_rises(160), 8);
        check("ign_sdo", sdo_at_rises(0), 8'hA5);

        // Reset at cycle 30 of a transfer.
        @(negedge clk);
        start_v = 1'b1;
        tx_v    = 8'h77;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            start_v = 1'b0;
        end
        check("pre_abort_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("abort_ce", bus.ce, 0);
        check("abort_sck", bus.sck, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_rx", bus.rx_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.ce) cnt++;
        end
        check("abort_no_done", cnt, 0);

        run(8'h5A, 80, 1, 8'h00, -1, -1);
        check("post_abort_done", pattern_errors(3, 80, 0, -1), 0);
        check("post_abort_rx", tr_rx[73], 8'h5A);
        check("post_abort_rcv", rcv_data, 8'h5A);
        check("post_abort_valid", rcv_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
